// File: rtl/uart_rx_sampler_if.sv
// FIFO push-side bundle between the UART receive sampler and the RX FIFO.
//
// Handshake: o_push is a one-cycle strobe and o_data is valid in that same
// cycle. There is no ready signal; i_full is looked at only when a stop bit
// is voted good, and a byte that finds i_full high is dropped (overrun).
interface uart_rx_sampler_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] o_data;
  logic                 o_push;
  logic                 i_full;

  // Sampler side: produces bytes, observes FIFO fullness.
  modport master (output o_data, output o_push, input i_full);
  // FIFO side: consumes bytes, reports fullness.
  modport slave  (input o_data, input o_push, output i_full);
endinterface

// File: rtl/uart_rx_sampler.sv
// Oversampling UART receive front-end: synchronises rx, detects start bits,
// takes a 2-of-3 majority vote around each bit centre, assembles LSB-first
// bytes and pushes good bytes into the RX FIFO. Framing errors and overruns
// are reported through sticky flags cleared by i_err_clr.
//
// Timing reference: E0 is the edge at which IDLE sees rx_s low; cnt is 0 in
// the cycle after E0 and after every bit boundary. The vote for bit k
// resolves at edge E0 + k*div_l + half + 1, i.e. the edge leaving the cycle
// where cnt == half. The two earlier samples are registered on the edges
// leaving cnt == half-2 and cnt == half-1.
// DATA_BITS must be at least 2 (the shift register slices [DATA_BITS-1:1]).
module uart_rx_sampler #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       clk_div,
  input  logic              rx,
  input  logic              i_err_clr,
  uart_rx_sampler_if.master fifo,
  output logic              o_frame_err,
  output logic              o_overrun,
  output logic              o_busy,
  output logic [2:0]        dbg_state
);

  // A single-flop synchroniser is not safe, so anything below 2 is raised.
  localparam int          SYNC_N  = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int          IDX_W   = $clog2(DATA_BITS + 1);
  localparam logic [31:0] MIN_DIV = 32'd8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t               state;
  state_t               state_n;
  logic [SYNC_N-1:0]    sync_q;
  logic                 rx_s;
  logic [31:0]          div_l;
  logic [31:0]          half;
  logic [31:0]          cnt;
  logic                 samp0;
  logic                 samp1;
  logic                 vote;
  logic                 at_s0;
  logic                 at_s1;
  logic                 at_vote;
  logic                 bit_end;
  logic                 last_bit;
  logic                 bit_next;
  logic                 cnt_clr;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 push_q;
  logic                 stop_ok;
  logic                 push_ev;
  logic                 ovr_ev;
  logic                 fe_ev;

  // Bring the asynchronous pad input into the clk domain; idle-high reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_N-2:0], rx};
    end
  end

  assign rx_s = sync_q[SYNC_N-1];

  // Sample-point decode relative to the latched bit period.
  assign half     = div_l >> 1;
  assign at_s0    = (cnt == half - 32'd2);
  assign at_s1    = (cnt == half - 32'd1);
  assign at_vote  = (cnt == half);
  assign bit_end  = (cnt == div_l - 32'd1);
  assign last_bit = (bit_idx == IDX_W'(DATA_BITS - 1));
  assign vote     = (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);

  // Frame-level events, all qualified by the stop-bit vote edge.
  assign stop_ok  = (state == STOP) && at_vote && vote;
  assign push_ev  = stop_ok && !fifo.i_full;
  assign ovr_ev   = stop_ok && fifo.i_full;
  assign fe_ev    = (state == STOP) && at_vote && !vote;
  assign bit_next = (state == DATA) && bit_end && !last_bit;

  // cnt restarts on every state entry and on every data-bit boundary, and is
  // parked at 0 while waiting in IDLE or WAIT_HIGH.
  assign cnt_clr = (state_n != state) || bit_next ||
                   (state_n == IDLE) || (state_n == WAIT_HIGH);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // FSM next-state logic. STOP leaves at the vote edge without waiting for
  // the end of the stop bit, so the next start bit is seen immediately.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (!rx_s) state_n = START;
      end
      START: begin
        if (at_vote && vote) state_n = IDLE;
        else if (bit_end)    state_n = DATA;
      end
      DATA: begin
        if (bit_end && last_bit) state_n = STOP;
      end
      STOP: begin
        if (at_vote) state_n = vote ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM outputs: busy outside IDLE, raw state exposed for debug.
  always_comb begin
    o_busy    = (state != IDLE);
    dbg_state = state;
  end

  // Per-bit cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 32'd1;
    end
  end

  // Bit period is frozen for the whole frame; too-small divisors clamp to 8.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_l <= MIN_DIV;
    end else if ((state == IDLE) && (state_n == START)) begin
      div_l <= (clk_div < MIN_DIV) ? MIN_DIV : clk_div;
    end
  end

  // First two of the three mid-bit samples; the third is the live rx_s.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp0 <= 1'b1;
      samp1 <= 1'b1;
    end else begin
      if (at_s0) samp0 <= rx_s;
      if (at_s1) samp1 <= rx_s;
    end
  end

  // Data-bit index: reset on entering DATA, advanced at each inner bit end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx <= '0;
    end else if ((state == START) && (state_n == DATA)) begin
      bit_idx <= '0;
    end else if (bit_next) begin
      bit_idx <= bit_idx + 1'b1;
    end
  end

  // LSB-first assembly: each vote enters at the MSB and walks down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
    end else if ((state == DATA) && at_vote) begin
      shift_q <= {vote, shift_q[DATA_BITS-1:1]};
    end
  end

  // Output byte and push strobe change together, one cycle after the vote.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      push_q <= 1'b0;
    end else begin
      push_q <= push_ev;
      if (push_ev) data_q <= shift_q;
    end
  end

  // Sticky error flags; a set in the same cycle as a clear keeps the flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      if (fe_ev)          o_frame_err <= 1'b1;
      else if (i_err_clr) o_frame_err <= 1'b0;
      if (ovr_ev)         o_overrun   <= 1'b1;
      else if (i_err_clr) o_overrun   <= 1'b0;
    end
  end

  assign fifo.o_data = data_q;
  assign fifo.o_push = push_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Self-checking bench for uart_rx_sampler: directed table, hand-written
// corner sequences and a randomized frame stream against a frame-level model.
module tb_uart_rx_sampler;
  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] clk_div = 32'd16;
  logic        rx = 1'b1;
  logic        i_err_clr = 1'b0;
  logic        o_frame_err;
  logic        o_overrun;
  logic        o_busy;
  logic [2:0]  dbg_state;

  uart_rx_sampler_if #(.DATA_BITS(W)) fifo_if();

  uart_rx_sampler #(.DATA_BITS(W), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_div     (clk_div),
    .rx          (rx),
    .i_err_clr   (i_err_clr),
    .fifo        (fifo_if),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun),
    .o_busy      (o_busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int             checks = 0;
  int             errors = 0;
  int             pushes = 0;
  logic [W-1:0]   exp_q[$];
  logic           prev_push = 1'b0;
  logic [W-1:0]   prev_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Push monitor: compares every push against the expected queue, and
  // checks strobe width and data stability on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_push = 1'b0;
      prev_data = fifo_if.o_data;
    end else begin
      if (fifo_if.o_push) begin
        pushes++;
        check("push_single", {31'd0, prev_push}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL push_unexpected actual=%0h required=no push", fifo_if.o_data);
        end else begin
          check("push_data", {24'd0, fifo_if.o_data}, {24'd0, exp_q.pop_front()});
        end
      end else begin
        check("data_stable", {24'd0, fifo_if.o_data}, {24'd0, prev_data});
      end
      prev_push = fifo_if.o_push;
      prev_data = fifo_if.o_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    i_err_clr = 1'b1;
    tick();
    i_err_clr = 1'b0;
  endtask

  // One 8N1 frame at 'div' cycles per bit; stop bit lasts stop_len cycles at
  // level stop_val. Cycle 'spike' (frame-relative, -1 for none) is inverted.
  task automatic send_frame(input logic [7:0] d, input int div, input int stop_len,
                            input bit stop_val, input int spike);
    int   total;
    int   pos;
    logic lvl;
    total = 9 * div + stop_len;
    for (int c = 0; c < total; c++) begin
      pos = c / div;
      if (pos == 0)      lvl = 1'b0;
      else if (pos <= 8) lvl = d[pos-1];
      else               lvl = stop_val;
      if (c == spike) lvl = ~lvl;
      rx = lvl;
      tick();
    end
    rx = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [7:0] data;
    int         div;
    int         bit_len;
    bit         stop_val;
    bit         full;
    bit         exp_push;
    logic [7:0] exp_data;
    bit         exp_fe;
    bit         exp_ov;
  } vec_t;

  vec_t vecs[8];

  // Watchdog: all loops are bounded, this only guards against a hang.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n0;
    int         cd;
    int         eff;
    int         sl;
    bit         sv;
    bit         fl;
    bit         saw_busy;
    bit         m_fe;
    bit         m_ov;
    logic [7:0] d;
    logic [7:0] rm_byte;
    int         pos;

    vecs[0] = '{8'hA5, 16, 16, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 16, 16, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0};
    vecs[2] = '{8'h81, 16, 16, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1};
    vecs[3] = '{8'h5A,  3,  8, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};
    vecs[4] = '{8'h01,  8,  8, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0};
    vecs[5] = '{8'hFF, 40, 40, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[6] = '{8'h00,  8,  8, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[7] = '{8'hC3,  7,  8, 1'b1, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0};

    fifo_if.i_full = 1'b0;

    // ---- reset ----
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", {24'd0, fifo_if.o_data}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    rst_n = 1'b1;
    repeat (4) tick();
    check("rst_push", {31'd0, fifo_if.o_push}, 32'd0);
    check("rst_fe", {31'd0, o_frame_err}, 32'd0);
    check("rst_ov", {31'd0, o_overrun}, 32'd0);
    check("rst_busy_rel", {31'd0, o_busy}, 32'd0);

    // ---- 3-cycle glitch: false start, no push, no flags ----
    clk_div = 32'd16;
    n0 = pushes;
    saw_busy = 1'b0;
    rx = 1'b0;
    repeat (3) tick();
    rx = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (o_busy) saw_busy = 1'b1;
    end
    check("glitch_started", {31'd0, saw_busy}, 32'd1);
    check("glitch_busy", {31'd0, o_busy}, 32'd0);
    check("glitch_push", pushes, n0);
    check("glitch_fe", {31'd0, o_frame_err}, 32'd0);
    check("glitch_ov", {31'd0, o_overrun}, 32'd0);

    // ---- mid-sample spike in data bit 3 of 0x0F ----
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 16, 16, 1'b1, 4 * 16 + 8);
    repeat (8) tick();
    check("spike_pending", exp_q.size(), 32'd0);
    check("spike_data", {24'd0, fifo_if.o_data}, 32'h0F);

    // ---- framing error with held break, then recovery ----
    n0 = pushes;
    send_frame(8'h3C, 16, 41 * 16, 1'b0, -1);
    check("break_fe", {31'd0, o_frame_err}, 32'd1);
    check("break_busy", {31'd0, o_busy}, 32'd1);
    check("break_push", pushes, n0);
    repeat (8) tick();
    check("break_idle", {31'd0, o_busy}, 32'd0);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 16, 16, 1'b1, -1);
    repeat (8) tick();
    check("recover_pending", exp_q.size(), 32'd0);
    check("recover_data", {24'd0, fifo_if.o_data}, 32'h55);
    check("recover_fe_sticky", {31'd0, o_frame_err}, 32'd1);
    pulse_clr();
    tick();
    check("fe_cleared", {31'd0, o_frame_err}, 32'd0);

    // ---- overrun, then overrun coincident with clear ----
    n0 = pushes;
    fifo_if.i_full = 1'b1;
    send_frame(8'h81, 16, 16, 1'b1, -1);
    repeat (8) tick();
    check("ovr_flag", {31'd0, o_overrun}, 32'd1);
    check("ovr_push", pushes, n0);
    check("ovr_data_held", {24'd0, fifo_if.o_data}, 32'h55);
    pulse_clr();
    tick();
    check("ovr_cleared", {31'd0, o_overrun}, 32'd0);
    // The stop vote edge is tick 9*div+half+4 counted from the first rx drive.
    fork
      send_frame(8'h81, 16, 16, 1'b1, -1);
      begin
        repeat (9 * 16 + 8 + 3) tick();
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
      end
    join
    repeat (4) tick();
    fifo_if.i_full = 1'b0;
    check("ovr_set_wins", {31'd0, o_overrun}, 32'd1);
    check("ovr2_push", pushes, n0);

    // ---- back-to-back frames, one-bit stop, no idle gap ----
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h12);
    send_frame(8'h00, 16, 16, 1'b1, -1);
    send_frame(8'hFF, 16, 16, 1'b1, -1);
    send_frame(8'h12, 16, 16, 1'b1, -1);
    repeat (8) tick();
    check("b2b_pending", exp_q.size(), 32'd0);
    check("b2b_data", {24'd0, fifo_if.o_data}, 32'h12);

    // ---- reset during data bit 4 ----
    n0 = pushes;
    rm_byte = 8'h77;
    for (int c = 0; c < 16 * 5 + 8; c++) begin
      pos = c / 16;
      rx = (pos == 0) ? 1'b0 : rm_byte[pos-1];
      tick();
    end
    rst_n = 1'b0;
    rx = 1'b1;
    tick();
    check("rstm_data", {24'd0, fifo_if.o_data}, 32'd0);
    check("rstm_push", {31'd0, fifo_if.o_push}, 32'd0);
    check("rstm_fe", {31'd0, o_frame_err}, 32'd0);
    check("rstm_ov", {31'd0, o_overrun}, 32'd0);
    check("rstm_busy", {31'd0, o_busy}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (40) tick();
    check("rstm_no_push", pushes, n0);
    check("rstm_idle", {31'd0, o_busy}, 32'd0);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 16, 16, 1'b1, -1);
    repeat (8) tick();
    check("rstm_next_pending", exp_q.size(), 32'd0);
    check("rstm_next_count", pushes, n0 + 1);

    // ---- divisor change in mid-frame ----
    exp_q.push_back(8'h6B);
    exp_q.push_back(8'h94);
    clk_div = 32'd16;
    fork
      send_frame(8'h6B, 16, 16, 1'b1, -1);
      begin
        repeat (40) tick();
        clk_div = 32'd32;
      end
    join
    repeat (4) tick();
    send_frame(8'h94, 32, 32, 1'b1, -1);
    repeat (8) tick();
    check("div_pending", exp_q.size(), 32'd0);

    // ---- directed vector table ----
    for (int v = 0; v < 8; v++) begin
      pulse_clr();
      clk_div = 32'(vecs[v].div);
      fifo_if.i_full = vecs[v].full;
      n0 = pushes;
      if (vecs[v].exp_push) exp_q.push_back(vecs[v].exp_data);
      send_frame(vecs[v].data, vecs[v].bit_len, vecs[v].bit_len, vecs[v].stop_val, -1);
      repeat (8) tick();
      fifo_if.i_full = 1'b0;
      check($sformatf("vec%0d_npush", v), pushes - n0, {31'd0, vecs[v].exp_push});
      check($sformatf("vec%0d_data", v), {24'd0, fifo_if.o_data}, {24'd0, vecs[v].exp_data});
      check($sformatf("vec%0d_fe", v), {31'd0, o_frame_err}, {31'd0, vecs[v].exp_fe});
      check($sformatf("vec%0d_ov", v), {31'd0, o_overrun}, {31'd0, vecs[v].exp_ov});
      check($sformatf("vec%0d_busy", v), {31'd0, o_busy}, 32'd0);
    end
    check("table_pending", exp_q.size(), 32'd0);

    // ---- randomized frames against the frame-level model ----
    // Model: a frame's bit length is max(clk_div, 8); a good stop with the
    // FIFO not full yields the byte, a good stop with it full sets overrun,
    // a low stop sets framing error; flags stay set until cleared.
    pulse_clr();
    m_fe = 1'b0;
    m_ov = 1'b0;
    for (int f = 0; f < 20; f++) begin
      d   = 8'($urandom);
      cd  = $urandom_range(3, 40);
      eff = (cd < 8) ? 8 : cd;
      sv  = ($urandom_range(0, 5) != 0);
      fl  = ($urandom_range(0, 3) == 0);
      sl  = $urandom_range(eff / 2 + 2, eff);
      if ($urandom_range(0, 3) == 0) begin
        pulse_clr();
        m_fe = 1'b0;
        m_ov = 1'b0;
      end
      clk_div = 32'(cd);
      fifo_if.i_full = fl;
      if (!sv)     m_fe = 1'b1;
      else if (fl) m_ov = 1'b1;
      else         exp_q.push_back(d);
      send_frame(d, eff, sl, sv, -1);
      repeat ($urandom_range(6, 20)) tick();
      fifo_if.i_full = 1'b0;
      check("rnd_fe", {31'd0, o_frame_err}, {31'd0, m_fe});
      check("rnd_ov", {31'd0, o_overrun}, {31'd0, m_ov});
      check("rnd_busy", {31'd0, o_busy}, 32'd0);
    end
    check("rnd_pending", exp_q.size(), 32'd0);

    // ---- report ----
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
